m_cycleacc: RTL and testbench



---
 rtl/m_cycleacc_pkg.sv | 19 +
 rtl/m_cycleacc_half.sv | 32 +++
 rtl/m_cycleacc.sv | 122 ++++++++++++
 tb/tb_m_cycleacc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/m_cycleacc_pkg.sv
// Shared definitions for the architectural cycle accumulator.
// Holds counter widths, the split-add state encoding and the addend width helper.
// Imported by m_cycleacc and m_cycleacc_half.
package m_cycleacc_pkg;

  localparam int CYCLE_W = 64;
  localparam int HALF_W  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ADD_HI = 1'b1
  } state_t;

  // The overflow flag sits directly above the count, so the addend is one bit wider.
  function automatic int addend_w(input int cntw);
    return cntw + 1;
  endfunction

endpackage

// File: rtl/m_cycleacc_half.sv
// One 32-bit half of the cycle counter: register with carry-in adder and write override.
// Latency: q updates at the edge after add_en/wr_en; sum/cout are combinational from q.
// Backpressure: none; wr_en always wins over add_en.
// Ports: clk, rst_n, add_en, addend, cin, wr_en, wr_data -> q, sum, cout.
module m_cycleacc_half
  import m_cycleacc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_en,
  input  logic [HALF_W-1:0] addend,
  input  logic              cin,
  input  logic              wr_en,
  input  logic [HALF_W-1:0] wr_data,
  output logic [HALF_W-1:0] q,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, q} + {1'b0, addend} + {{HALF_W{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_en) begin
      q <= wr_data;
    end else if (add_en) begin
      q <= sum;
    end
  end

endmodule

// File: rtl/m_cycleacc.sv
// Adds per-instruction cycle counts into the 64-bit mcycle/mcycleh counter; serves CSR reads/writes.
// Latency: SPLIT=1 lo +1 cycle, hi +2 cycles after accept; SPLIT=0 both +1 cycle. Reads: rd_data +1 cycle.
// Backpressure: ccnt_ready low in ADD_HI and in any cycle carrying a CSR write.
// Ports: ccnt_valid/ccnt/ccnt_ovf/ccnt_ready (count handoff), rd_lo/rd_hi -> rd_data/rd_valid,
//        wr_lo/wr_hi/wr_data (CSR writes).
module m_cycleacc
  import m_cycleacc_pkg::*;
#(
  parameter int CNTW  = 6,
  parameter int SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ccnt_valid,
  input  logic [CNTW-1:0]   ccnt,
  input  logic              ccnt_ovf,
  output logic              ccnt_ready,
  input  logic              rd_lo,
  input  logic              rd_hi,
  output logic [HALF_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wr_data
);

  localparam int AW = addend_w(CNTW);

  state_t            state_q, state_d;
  logic              carry_q;
  logic              accept;
  logic [HALF_W-1:0] lo_addend;
  logic [HALF_W-1:0] lo_q, lo_sum;
  logic              lo_cout;
  logic [HALF_W-1:0] hi_q, hi_sum;
  logic              hi_cout_unused;
  logic              hi_add_en;
  logic              hi_cin;
  logic [HALF_W-1:0] snap_src;
  logic [HALF_W-1:0] snap_hi;

  assign ccnt_ready = (state_q == IDLE) & ~wr_lo & ~wr_hi;
  assign accept     = ccnt_valid & ccnt_ready;
  assign lo_addend  = {{(HALF_W-AW){1'b0}}, ccnt_ovf, ccnt};

  // carry_q is only non-zero during ADD_HI, so hi_sum is the post-ADD_HI value in
  // both states; that makes it the coherent high word for a snapshot.
  always_comb begin
    hi_add_en = 1'b0;
    hi_cin    = 1'b0;
    snap_src  = hi_q;
    state_d   = state_q;
    if (SPLIT != 0) begin
      hi_add_en = (state_q == ADD_HI);
      hi_cin    = carry_q;
      snap_src  = hi_sum;
      case (state_q)
        IDLE:    if (accept) state_d = ADD_HI;
        ADD_HI:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      hi_add_en = accept;
      hi_cin    = lo_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= (SPLIT != 0) && accept && lo_cout;
    end
  end

  m_cycleacc_half u_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_en  (accept),
    .addend  (lo_addend),
    .cin     (1'b0),
    .wr_en   (wr_lo),
    .wr_data (wr_data),
    .q       (lo_q),
    .sum     (lo_sum),
    .cout    (lo_cout)
  );

  // wr_en overrides add_en inside the half, so a wr_hi during ADD_HI drops the carry.
  m_cycleacc_half u_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_en  (hi_add_en),
    .addend  ({HALF_W{1'b0}}),
    .cin     (hi_cin),
    .wr_en   (wr_hi),
    .wr_data (wr_data),
    .q       (hi_q),
    .sum     (hi_sum),
    .cout    (hi_cout_unused)
  );

  // rd_lo has priority and captures the matching high word; rd_hi replays it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      snap_hi  <= '0;
    end else begin
      rd_valid <= rd_lo | rd_hi;
      if (rd_lo) begin
        rd_data <= lo_q;
        snap_hi <= snap_src;
      end else if (rd_hi) begin
        rd_data <= snap_hi;
      end
    end
  end

endmodule

// File: tb/tb_m_cycleacc.sv
module tb_m_cycleacc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ccnt_valid;
  logic [5:0]  ccnt;
  logic        ccnt_ovf;
  logic        ccnt_ready;
  logic        rd_lo, rd_hi;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_lo, wr_hi;
  logic [31:0] wr_data;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] v;

  always #5 clk = ~clk;

  m_cycleacc #(.CNTW(6), .SPLIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ccnt_valid(ccnt_valid), .ccnt(ccnt), .ccnt_ovf(ccnt_ovf), .ccnt_ready(ccnt_ready),
    .rd_lo(rd_lo), .rd_hi(rd_hi), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_lo(wr_lo), .wr_hi(wr_hi), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic hi, input logic [31:0] d);
    wr_lo = ~hi; wr_hi = hi; wr_data = d;
    step();
    wr_lo = 0; wr_hi = 0;
  endtask

  task automatic wr64(input logic [63:0] d);
    wr(1'b0, d[31:0]);
    wr(1'b1, d[63:32]);
  endtask

  task automatic count(input logic [5:0] c, input logic o);
    ccnt_valid = 1; ccnt = c; ccnt_ovf = o;
    step();
    ccnt_valid = 0; ccnt = 0; ccnt_ovf = 0;
    step();
  endtask

  task automatic read64(output logic [63:0] r);
    rd_lo = 1;
    step();
    rd_lo = 0;
    r[31:0] = rd_data;
    rd_hi = 1;
    step();
    rd_hi = 0;
    r[63:32] = rd_data;
  endtask

  initial begin
    rst_n = 0; ccnt_valid = 0; ccnt = 0; ccnt_ovf = 0;
    rd_lo = 0; rd_hi = 0; wr_lo = 0; wr_hi = 0; wr_data = 0;
    #12;
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    step();
    rst_n = 1;
    #1;
    chk("rst_ready", 64'(ccnt_ready), 64'h1);
    rd_hi = 1;
    step();
    rd_hi = 0;
    chk("rst_rdhi_valid", 64'(rd_valid), 64'h1);
    chk("rst_rdhi_data", 64'(rd_data), 64'h0);
    step();
    chk("rd_valid_pulse", 64'(rd_valid), 64'h0);

    // ccnt=5: ready drops for exactly the ADD_HI cycle
    ccnt_valid = 1; ccnt = 5;
    #1 chk("t1_ready_idle", 64'(ccnt_ready), 64'h1);
    step();
    ccnt_valid = 0; ccnt = 0;
    #1 chk("t1_ready_addhi", 64'(ccnt_ready), 64'h0);
    step();
    chk("t1_ready_back", 64'(ccnt_ready), 64'h1);
    read64(v);
    chk("t1_acc", v, 64'h0000_0000_0000_0005);

    // carry into the high half; rd_lo issued in the ADD_HI cycle sees a coherent pair
    wr64(64'h0000_0000_FFFF_FFFE);
    ccnt_valid = 1; ccnt = 3;
    step();
    ccnt_valid = 0; ccnt = 0;
    rd_lo = 1;
    step();
    rd_lo = 0;
    chk("t2_lo_addhi", 64'(rd_data), 64'h1);
    rd_hi = 1;
    step();
    rd_hi = 0;
    chk("t2_hi_snap", 64'(rd_data), 64'h1);
    read64(v);
    chk("t2_acc", v, 64'h0000_0001_0000_0001);

    // overflow flag alone adds 64
    count(6'd0, 1'b1);
    read64(v);
    chk("t3_ovf", v, 64'h0000_0001_0000_0041);

    // 64-bit wrap to zero
    wr64(64'hFFFF_FFFF_FFFF_FFC0);
    count(6'd0, 1'b1);
    read64(v);
    chk("t3_wrap", v, 64'h0);

    // largest addend: 63 + 64
    count(6'd63, 1'b1);
    read64(v);
    chk("t3_max", v, 64'h0000_0000_0000_007F);

    // write blocks acceptance; count lands the next cycle
    ccnt_valid = 1; ccnt = 7; wr_hi = 1; wr_data = 32'h0000_0010;
    #1 chk("t5_ready_wr", 64'(ccnt_ready), 64'h0);
    step();
    wr_hi = 0;
    #1 chk("t5_ready_after", 64'(ccnt_ready), 64'h1);
    step();
    ccnt_valid = 0; ccnt = 0;
    step();
    read64(v);
    chk("t5_acc", v, 64'h0000_0010_0000_0086);

    // read with write in the same cycle returns the pre-write value
    rd_lo = 1; wr_lo = 1; wr_data = 32'h0000_AAAA;
    step();
    rd_lo = 0; wr_lo = 0;
    chk("rw_same", 64'(rd_data), 64'h86);
    read64(v);
    chk("rw_after", v, 64'h0000_0010_0000_AAAA);

    // rd_lo and rd_hi together: lo wins
    rd_lo = 1; rd_hi = 1;
    step();
    rd_lo = 0; rd_hi = 0;
    chk("rdboth", 64'(rd_data), 64'hAAAA);

    // wr_hi during ADD_HI discards the carry
    wr64(64'h0000_0005_FFFF_FFFF);
    ccnt_valid = 1; ccnt = 1;
    step();
    ccnt_valid = 0; ccnt = 0;
    wr_hi = 1; wr_data = 32'h20;
    step();
    wr_hi = 0;
    read64(v);
    chk("wrhi_addhi", v, 64'h0000_0020_0000_0000);

    // wr_lo during ADD_HI: hi still takes the carry
    wr64(64'h0000_0005_FFFF_FFFF);
    ccnt_valid = 1; ccnt = 1;
    step();
    ccnt_valid = 0; ccnt = 0;
    wr_lo = 1; wr_data = 32'h1234;
    step();
    wr_lo = 0;
    read64(v);
    chk("wrlo_addhi", v, 64'h0000_0006_0000_1234);

    // reset during ADD_HI
    wr64(64'h0000_0003_FFFF_FFFF);
    rd_lo = 1;
    step();
    rd_lo = 0;
    ccnt_valid = 1; ccnt = 2; rd_hi = 1;
    step();
    ccnt_valid = 0; ccnt = 0; rd_hi = 0;
    chk("rst_mid_pre_valid", 64'(rd_valid), 64'h1);
    rst_n = 0;
    #1;
    chk("rst_mid_valid", 64'(rd_valid), 64'h0);
    chk("rst_mid_data", 64'(rd_data), 64'h0);
    step();
    rst_n = 1;
    #1 chk("rst_mid_ready", 64'(ccnt_ready), 64'h1);
    rd_hi = 1;
    step();
    rd_hi = 0;
    chk("rst_mid_rdhi", 64'(rd_data), 64'h0);
    step();
    read64(v);
    chk("rst_mid_acc", v, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
